battleship_game_ctrl: RTL and testbench

Top-level game sequencer for the 5x5 battleship VGA game. Drives the `tablero` board datapath's phase inputs:

- ship placement, PC setup, player turn, PC turn and decision;
- the merged attack-confirm strobe, with a per-turn countdown that forces an attack on timeout;
- the latched ship count.

Sits between the debounced board buttons/switches and `tablero`. Its state code and countdown also feed the VGA text overlay.

---
 rtl/battleship_pkg.sv | 44 ++++
 rtl/battleship_game_ctrl_if.sv | 36 +++
 rtl/battleship_game_ctrl_turn_timer.sv | 69 ++++++
 rtl/battleship_game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_battleship_game_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/battleship_pkg.sv
// Shared types and constants for the 5x5 battleship game: sequencer states,
// overlay state codes and board cell encodings used by tablero.
package battleship_pkg;

   localparam int unsigned BOARD_N = 5;
   localparam int unsigned CODE_W  = 3;

   localparam logic [1:0] AGUA        = 2'd0;
   localparam logic [1:0] BARCO       = 2'd1;
   localparam logic [1:0] ATACA_BARCO = 2'd2;
   localparam logic [1:0] ATACA_AGUA  = 2'd3;

   localparam logic [CODE_W-1:0] CODE_WIN  = 3'd0;
   localparam logic [CODE_W-1:0] CODE_LOSE = 3'd7;

   // Codes 0..7 match the overlay; WIN/LOSE/RESTART live above the 3-bit range
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_PLACE    = 4'd1,
      ST_PC_SETUP = 4'd2,
      ST_P_TURN   = 4'd3,
      ST_DEC_P    = 4'd4,
      ST_PC_WAIT  = 4'd5,
      ST_PC_TURN  = 4'd6,
      ST_DEC_C    = 4'd7,
      ST_WIN      = 4'd8,
      ST_LOSE     = 4'd9,
      ST_RESTART  = 4'd10
   } state_e;

   // Overlay code for a state; terminal states are only reported via game_over
   function automatic logic [CODE_W-1:0] state_code(input state_e s, input logic over);
      logic [3:0] raw;
      raw = s;
      if (over) begin
         return (s == ST_LOSE) ? CODE_LOSE : CODE_WIN;
      end
      if (s == ST_RESTART) begin
         return 3'd0;
      end
      return raw[CODE_W-1:0];
   endfunction

endpackage

// File: rtl/battleship_game_ctrl_if.sv
// Phase handshake between the game sequencer (master) and the tablero board (slave).
interface battleship_game_ctrl_if;

   logic       finished_placing;
   logic       finished_setUp;
   logic       player_has_move;
   logic       pc_has_move;
   logic       pc_ships_zero;
   logic       player_ships_zero;

   logic       colocation_ships_State;
   logic       setup_State;
   logic       player_turn_State;
   logic       pc_turn_State;
   logic       decision_State;
   logic       confirm_attack_player_to_pc;
   logic [2:0] player_ship_amount_define;
   logic       board_rst;

   modport master (
      input  finished_placing, finished_setUp, player_has_move, pc_has_move,
             pc_ships_zero, player_ships_zero,
      output colocation_ships_State, setup_State, player_turn_State, pc_turn_State,
             decision_State, confirm_attack_player_to_pc, player_ship_amount_define,
             board_rst
   );

   modport slave (
      output finished_placing, finished_setUp, player_has_move, pc_has_move,
             pc_ships_zero, player_ships_zero,
      input  colocation_ships_State, setup_State, player_turn_State, pc_turn_State,
             decision_State, confirm_attack_player_to_pc, player_ship_amount_define,
             board_rst
   );

endinterface

// File: rtl/battleship_game_ctrl_turn_timer.sv
// Player turn countdown: 1 s prescaler, saturating seconds counter and a
// single expiry strobe per turn, coincident with seconds_left reaching 0.
module turn_timer #(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned TURN_SECONDS = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       enable,
   output logic [3:0] seconds_left,
   output logic       expire
);

   localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [3:0]         sec_q, sec_d;
   logic               fired_q, fired_d;
   logic               expire_q, expire_d;
   logic               tick_c;

   always_comb begin
      presc_d  = presc_q;
      sec_d    = sec_q;
      fired_d  = fired_q;
      expire_d = 1'b0;
      tick_c   = enable && (presc_q == PRESC_W'(CLK_HZ - 1));
      if (load) begin
         presc_d = '0;
         sec_d   = 4'(TURN_SECONDS);
         fired_d = 1'b0;
      end else if (!enable) begin
         // Outside the player turn the counter reads 0
         presc_d = '0;
         sec_d   = 4'd0;
         fired_d = 1'b0;
      end else if (tick_c) begin
         presc_d = '0;
         if (sec_q != 4'd0) begin
            sec_d = sec_q - 4'd1;
         end
         if ((sec_q == 4'd1) && !fired_q) begin
            expire_d = 1'b1;
            fired_d  = 1'b1;
         end
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q  <= '0;
         sec_q    <= 4'd0;
         fired_q  <= 1'b0;
         expire_q <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         sec_q    <= sec_d;
         fired_q  <= fired_d;
         expire_q <= expire_d;
      end
   end

   assign seconds_left = sec_q;
   assign expire       = expire_q;

endmodule

// File: rtl/battleship_game_ctrl.sv
// Top-level game sequencer: walks tablero through placement, setup, player
// and PC turns, merges the player/timeout attack strobe and feeds the overlay.
module battleship_game_ctrl
   import battleship_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned TURN_SECONDS = 15,
   parameter int unsigned PC_DELAY     = 25_000_000,
   parameter int unsigned MAX_SHIPS    = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_btn,
   input  logic                   attack_btn,
   input  logic [2:0]             ship_amount_sw,
   battleship_game_ctrl_if.master bus,
   output logic [CODE_W-1:0]      game_state,
   output logic [3:0]             seconds_left
);

   localparam int unsigned WAIT_W = (PC_DELAY > 1) ? $clog2(PC_DELAY) : 1;

   state_e              state_q, state_d;
   logic                start_prev_q, start_prev_d;
   logic [2:0]          amount_q, amount_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                game_over_q, game_over_d;
   logic                coloc_q, coloc_d;
   logic                setup_q, setup_d;
   logic                pturn_q, pturn_d;
   logic                pcturn_q, pcturn_d;
   logic                decision_q, decision_d;
   logic                confirm_q, confirm_d;
   logic                board_rst_q, board_rst_d;
   logic [CODE_W-1:0]   game_state_q, game_state_d;

   logic                start_rise_c;
   logic                amount_ok_c;
   logic                timer_load_c;
   logic                timer_en_c;
   logic                timer_expire;
   logic                unused_pc_move_c;

   // The PC turn is a fixed single cycle, so the board's PC move flag is not needed
   assign unused_pc_move_c = bus.pc_has_move;

   turn_timer #(
      .CLK_HZ       (CLK_HZ),
      .TURN_SECONDS (TURN_SECONDS)
   ) u_turn_timer (
      .clk          (clk),
      .rst          (rst),
      .load         (timer_load_c),
      .enable       (timer_en_c),
      .seconds_left (seconds_left),
      .expire       (timer_expire)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d      = state_q;
      amount_d     = amount_q;
      wait_d       = '0;
      start_prev_d = start_btn;
      start_rise_c = start_btn && !start_prev_q;
      amount_ok_c  = (ship_amount_sw != 3'd0) && (32'(ship_amount_sw) <= MAX_SHIPS);

      case (state_q)
         ST_IDLE: begin
            if (start_rise_c && amount_ok_c) begin
               state_d  = ST_PLACE;
               amount_d = ship_amount_sw;
            end
         end
         ST_PLACE: begin
            if (bus.finished_placing) state_d = ST_PC_SETUP;
         end
         ST_PC_SETUP: begin
            if (bus.finished_setUp) state_d = ST_P_TURN;
         end
         ST_P_TURN: begin
            if (bus.player_has_move) state_d = ST_DEC_P;
         end
         ST_DEC_P: begin
            state_d = bus.pc_ships_zero ? ST_WIN : ST_PC_WAIT;
         end
         ST_PC_WAIT: begin
            if (wait_q == WAIT_W'(PC_DELAY - 1)) begin
               state_d = ST_PC_TURN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_PC_TURN: begin
            state_d = ST_DEC_C;
         end
         ST_DEC_C: begin
            state_d = bus.player_ships_zero ? ST_LOSE : ST_P_TURN;
         end
         ST_WIN, ST_LOSE: begin
            if (game_over_q && start_rise_c) state_d = ST_RESTART;
         end
         ST_RESTART: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      timer_load_c = (state_d == ST_P_TURN) && (state_q != ST_P_TURN);
      timer_en_c   = (state_d == ST_P_TURN);

      // Outputs are decoded from the next state so they register alongside it
      coloc_d      = (state_d == ST_PLACE);
      setup_d      = (state_d == ST_PC_SETUP);
      pturn_d      = (state_d == ST_P_TURN);
      pcturn_d     = (state_d == ST_PC_TURN);
      decision_d   = (state_d == ST_DEC_P) || (state_d == ST_DEC_C);
      game_over_d  = (state_d == ST_WIN) || (state_d == ST_LOSE);
      board_rst_d  = (state_d != ST_RESTART);
      game_state_d = state_code(state_d, game_over_d);
      confirm_d    = attack_btn || timer_expire;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         amount_q     <= 3'd0;
         wait_q       <= '0;
         game_over_q  <= 1'b0;
         coloc_q      <= 1'b0;
         setup_q      <= 1'b0;
         pturn_q      <= 1'b0;
         pcturn_q     <= 1'b0;
         decision_q   <= 1'b0;
         confirm_q    <= 1'b0;
         board_rst_q  <= 1'b0;
         game_state_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         amount_q     <= amount_d;
         wait_q       <= wait_d;
         game_over_q  <= game_over_d;
         coloc_q      <= coloc_d;
         setup_q      <= setup_d;
         pturn_q      <= pturn_d;
         pcturn_q     <= pcturn_d;
         decision_q   <= decision_d;
         confirm_q    <= confirm_d;
         board_rst_q  <= board_rst_d;
         game_state_q <= game_state_d;
      end
   end

   assign bus.colocation_ships_State      = coloc_q;
   assign bus.setup_State                 = setup_q;
   assign bus.player_turn_State           = pturn_q;
   assign bus.pc_turn_State               = pcturn_q;
   assign bus.decision_State              = decision_q;
   assign bus.confirm_attack_player_to_pc = confirm_q;
   assign bus.player_ship_amount_define   = amount_q;
   assign bus.board_rst                   = board_rst_q;
   assign game_state                      = game_state_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Vector-table bench for battleship_game_ctrl with a scoreboard queue of
// expected outputs, plus a hand-written asynchronous reset sequence.
module tb_battleship_game_ctrl;

   typedef struct packed {
      logic       st;
      logic       atk;
      logic [2:0] sw;
      logic       fp;
      logic       fs;
      logic       phm;
      logic       pcz;
      logic       plz;
   } in_t;

   typedef struct packed {
      logic [4:0] en;     // {colocation, setup, player_turn, pc_turn, decision}
      logic       conf;
      logic [2:0] amt;
      logic       brst;
      logic [2:0] gs;
      logic [3:0] sec;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   localparam logic [4:0] EN_NONE = 5'b00000;
   localparam logic [4:0] EN_PL   = 5'b10000;
   localparam logic [4:0] EN_SU   = 5'b01000;
   localparam logic [4:0] EN_PT   = 5'b00100;
   localparam logic [4:0] EN_PC   = 5'b00010;
   localparam logic [4:0] EN_DC   = 5'b00001;

   logic       clk;
   logic       rst_n;
   logic       start_btn;
   logic       attack_btn;
   logic [2:0] ship_amount_sw;
   logic [2:0] game_state;
   logic [3:0] seconds_left;

   battleship_game_ctrl_if bus();

   battleship_game_ctrl #(
      .CLK_HZ       (4),
      .TURN_SECONDS (3),
      .PC_DELAY     (2),
      .MAX_SHIPS    (5)
   ) dut (
      .clk            (clk),
      .rst            (rst_n),
      .start_btn      (start_btn),
      .attack_btn     (attack_btn),
      .ship_amount_sw (ship_amount_sw),
      .bus            (bus),
      .game_state     (game_state),
      .seconds_left   (seconds_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t vecs[$];
   out_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic in_t mk_i(int st, int atk, int sw, int fp, int fs, int phm, int pcz, int plz);
      in_t r;
      r.st = 1'(st); r.atk = 1'(atk); r.sw = 3'(sw);
      r.fp = 1'(fp); r.fs = 1'(fs); r.phm = 1'(phm); r.pcz = 1'(pcz); r.plz = 1'(plz);
      return r;
   endfunction

   function automatic out_t mk_o(logic [4:0] en, int conf, int amt, int brst, int gs, int sec);
      out_t r;
      r.en = en; r.conf = 1'(conf); r.amt = 3'(amt);
      r.brst = 1'(brst); r.gs = 3'(gs); r.sec = 4'(sec);
      return r;
   endfunction

   function automatic void add(in_t i, out_t o);
      vec_t v;
      v.i = i;
      v.o = o;
      vecs.push_back(v);
   endfunction

   task automatic drive(input in_t i);
      start_btn                 = i.st;
      attack_btn                = i.atk;
      ship_amount_sw            = i.sw;
      bus.finished_placing      = i.fp;
      bus.finished_setUp        = i.fs;
      bus.player_has_move       = i.phm;
      bus.pc_ships_zero         = i.pcz;
      bus.player_ships_zero     = i.plz;
      bus.pc_has_move           = 1'b0;
   endtask

   task automatic check(input string name);
      out_t act;
      out_t exp;
      act = {bus.colocation_ships_State, bus.setup_State, bus.player_turn_State,
             bus.pc_turn_State, bus.decision_State, bus.confirm_attack_player_to_pc,
             bus.player_ship_amount_define, bus.board_rst, game_state, seconds_left};
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty, got %h", name, act);
      end else begin
         exp = sb.pop_front();
         if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got en=%b conf=%b amt=%0d brst=%b gs=%0d sec=%0d, expected en=%b conf=%b amt=%0d brst=%b gs=%0d sec=%0d",
                     name, act.en, act.conf, act.amt, act.brst, act.gs, act.sec,
                     exp.en, exp.conf, exp.amt, exp.brst, exp.gs, exp.sec);
         end
      end
   endtask

   initial begin
      // Game 1: range checks, countdown with forced confirm, PC turn, then LOSE
      add(mk_i(0,0,0,0,0,0,0,0), mk_o(EN_NONE,0,0,1,0,0));
      add(mk_i(0,1,0,0,0,0,0,0), mk_o(EN_NONE,1,0,1,0,0));
      add(mk_i(1,0,0,0,0,0,0,0), mk_o(EN_NONE,0,0,1,0,0));
      add(mk_i(0,0,6,0,0,0,0,0), mk_o(EN_NONE,0,0,1,0,0));
      add(mk_i(1,0,6,0,0,0,0,0), mk_o(EN_NONE,0,0,1,0,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_NONE,0,0,1,0,0));
      add(mk_i(1,0,3,0,0,0,0,0), mk_o(EN_PL,0,3,1,1,0));
      add(mk_i(1,0,3,0,0,0,0,0), mk_o(EN_PL,0,3,1,1,0));
      add(mk_i(0,0,3,1,0,0,0,0), mk_o(EN_SU,0,3,1,2,0));
      add(mk_i(0,0,3,0,1,0,0,0), mk_o(EN_PT,0,3,1,3,3));
      for (int k = 1; k <= 15; k++) begin
         int s;
         s = (k <= 3) ? 3 : (k <= 7) ? 2 : (k <= 11) ? 1 : 0;
         add(mk_i(0, int'(k == 13), 3,0,0,0,0,0), mk_o(EN_PT, int'(k == 13), 3,1,3,s));
      end
      add(mk_i(0,0,3,0,0,1,0,0), mk_o(EN_DC,0,3,1,4,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,1,5,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,1,5,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_PC,0,3,1,6,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_DC,0,3,1,7,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_PT,0,3,1,3,3));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_PT,0,3,1,3,3));
      add(mk_i(0,0,3,0,0,1,0,0), mk_o(EN_DC,0,3,1,4,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,1,5,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,1,5,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_PC,0,3,1,6,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_DC,0,3,1,7,0));
      add(mk_i(0,0,3,0,0,0,0,1), mk_o(EN_NONE,0,3,1,7,0));
      add(mk_i(0,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,1,7,0));
      add(mk_i(1,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,0,0,0));
      add(mk_i(1,0,3,0,0,0,0,0), mk_o(EN_NONE,0,3,1,0,0));
      add(mk_i(0,0,5,0,0,0,0,0), mk_o(EN_NONE,0,3,1,0,0));
      // Game 2: MAX_SHIPS accepted, player sinks everything -> WIN
      add(mk_i(1,0,5,0,0,0,0,0), mk_o(EN_PL,0,5,1,1,0));
      add(mk_i(0,0,5,1,0,0,0,0), mk_o(EN_SU,0,5,1,2,0));
      add(mk_i(0,0,5,0,1,0,0,0), mk_o(EN_PT,0,5,1,3,3));
      add(mk_i(0,0,5,0,0,1,0,0), mk_o(EN_DC,0,5,1,4,0));
      add(mk_i(0,0,5,0,0,0,1,0), mk_o(EN_NONE,0,5,1,0,0));
      add(mk_i(0,0,2,0,0,0,0,0), mk_o(EN_NONE,0,5,1,0,0));
      // Start in WIN restarts the board rather than starting placement
      add(mk_i(1,0,2,0,0,0,0,0), mk_o(EN_NONE,0,5,0,0,0));
      add(mk_i(1,0,2,0,0,0,0,0), mk_o(EN_NONE,0,5,1,0,0));
      add(mk_i(0,0,2,0,0,0,0,0), mk_o(EN_NONE,0,5,1,0,0));
      // Game 3: run into PC_WAIT for the reset check
      add(mk_i(1,0,2,0,0,0,0,0), mk_o(EN_PL,0,2,1,1,0));
      add(mk_i(0,0,2,1,0,0,0,0), mk_o(EN_SU,0,2,1,2,0));
      add(mk_i(0,0,2,0,1,0,0,0), mk_o(EN_PT,0,2,1,3,3));
      add(mk_i(0,0,2,0,0,1,0,0), mk_o(EN_DC,0,2,1,4,0));
      add(mk_i(0,0,2,0,0,0,0,0), mk_o(EN_NONE,0,2,1,5,0));

      drive(mk_i(0,0,0,0,0,0,0,0));
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(mk_o(EN_NONE,0,0,0,0,0));
      check("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[n]) begin
         @(negedge clk);
         drive(vecs[n].i);
         sb.push_back(vecs[n].o);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", n));
      end

      // Asynchronous reset in PC_WAIT, mid clock-high phase
      #2 rst_n = 1'b0;
      #1;
      sb.push_back(mk_o(EN_NONE,0,0,0,0,0));
      check("async_reset_immediate");
      @(posedge clk);
      #1;
      sb.push_back(mk_o(EN_NONE,0,0,0,0,0));
      check("async_reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(mk_o(EN_NONE,0,0,1,0,0));
      check("after_reset_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
